// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
// -----------------
// Round-robin arbiter that time-shares one external combinational ALU
// (AND / OR / add / subtract) among NUM_REQ requesters.
//
// A request is accepted in IDLE with a one-cycle req_ready pulse. Its operands
// are latched into registers that drive the shared ALU during EXEC. The ALU
// result is captured at the end of EXEC and offered in RESP on a valid/ready
// response channel, tagged with the requester index.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   req_valid       per-requester request valid
//   req_ready       one-hot accept pulse (combinational, IDLE only)
//   req_a, req_b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op          packed op codes, requester i at [i*2 +: 2]
//                   (00 AND, 01 OR, 10 add, 11 sub A-B)
//   alu_a, alu_b    registered operands to the shared ALU
//   alu_control     registered op code to the shared ALU
//   alu_result      result from the shared ALU
//   resp_valid      response valid (RESP state)
//   resp_ready      response consumer ready
//   resp_id         index of the served requester
//   resp_result     registered ALU result
//   resp_zero       resp_result == 0
//   busy            scheduler is not idle
module alu_req_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [1:0]               alu_control,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_zero,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t             state_r;
  logic [IDW-1:0]     rr_ptr_r;
  logic [IDW-1:0]     grant_id_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   result_r;
  logic               zero_r;
  logic               busy_r;
  logic               resp_valid_r;

  logic               gnt_found_s;
  logic [IDW-1:0]     gnt_idx_s;
  logic [NUM_REQ-1:0] req_ready_s;

  // Index following id, wrapping from NUM_REQ-1 back to 0 (NUM_REQ need not
  // be a power of two, so plain IDW-bit overflow is not enough).
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
    if (id == IDW'(NUM_REQ - 1)) begin
      return {IDW{1'b0}};
    end else begin
      return id + IDW'(1);
    end
  endfunction

  // Round-robin pick: first valid requester scanning upward from rr_ptr_r.
  always_comb begin
    int idx_v;
    gnt_found_s = 1'b0;
    gnt_idx_s   = {IDW{1'b0}};
    idx_v       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!gnt_found_s && req_valid[idx_v]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = IDW'(idx_v);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Accept pulse: only in IDLE, only to the selected requester.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    if ((state_r == ST_IDLE) && gnt_found_s) begin
      req_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      req_ready_s = {NUM_REQ{1'b0}};
    end
  end

  // Scheduler FSM with its operand, result and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {IDW{1'b0}};
      grant_id_r   <= {IDW{1'b0}};
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      op_r         <= 2'b00;
      result_r     <= {WIDTH{1'b0}};
      zero_r       <= 1'b1;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_found_s) begin
            // Operands are only ever loaded here, so the ALU inputs hold
            // their last values outside EXEC.
            a_r        <= req_a[int'(gnt_idx_s)*WIDTH +: WIDTH];
            b_r        <= req_b[int'(gnt_idx_s)*2*0 + int'(gnt_idx_s)*WIDTH +: WIDTH];
            op_r       <= req_op[int'(gnt_idx_s)*2 +: 2];
            grant_id_r <= gnt_idx_s;
            busy_r     <= 1'b1;
            state_r    <= ST_EXEC;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // The ALU is combinational; its output already reflects a_r/b_r/op_r.
          result_r     <= alu_result;
          zero_r       <= (alu_result == {WIDTH{1'b0}});
          resp_valid_r <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            // The just-served requester drops to lowest priority.
            rr_ptr_r     <= wrap_inc(grant_id_r);
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            state_r      <= ST_RESP;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_s;
  assign alu_a       = a_r;
  assign alu_b       = b_r;
  assign alu_control = op_r;
  assign resp_valid  = resp_valid_r;
  assign resp_id     = grant_id_r;
  assign resp_result = result_r;
  assign resp_zero   = zero_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [1:0]     alu_control;
  logic [W-1:0]   alu_result;
  logic           resp_valid;
  logic           resp_ready;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_result;
  logic           resp_zero;
  logic           busy;

  always #5 clk = ~clk;

  alu_req_scheduler #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_zero(resp_zero),
    .busy(busy)
  );

  // 4-bit ALU: carry/borrow discarded.
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  // Shared ALU sitting beside the scheduler.
  assign alu_result = alu_ref(alu_a, alu_b, alu_control);

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Logs of observed handshakes (cycle numbers from the checker).
  int       g_id_q[$];
  int       g_cyc_q[$];
  int       r_id_q[$];
  int       r_cyc_q[$];
  logic [3:0] r_res_q[$];
  logic     r_zero_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: pending job with its accept cycle.
  int         m_ptr;
  bit         m_pend;
  int         m_acc;
  int         m_id;
  logic [3:0] m_res, m_last, m_a, m_b;
  logic [1:0] m_op;

  initial begin
    m_ptr = 0; m_pend = 1'b0; m_acc = 0; m_id = 0;
    m_res = 4'd0; m_last = 4'd0; m_a = 4'd0; m_b = 4'd0; m_op = 2'd0;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        int g;
        logic [N-1:0] exp_rdy;
        bit exp_rv;
        g = -1;
        if (!m_pend) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = m_pend && ((cyc - m_acc) >= 2);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_control", 32'(alu_control), 32'(m_op));
        chk("resp_zero", 32'(resp_zero), 32'(m_last == 4'd0));
        if (exp_rv) begin
          chk("resp_id", 32'(resp_id), 32'(m_id));
          chk("resp_result", 32'(resp_result), 32'(m_res));
        end
        if (!rst) begin
          for (int k = 0; k < N; k++) begin
            if (req_ready[k]) begin
              g_id_q.push_back(k);
              g_cyc_q.push_back(cyc);
            end
          end
          if (resp_valid && resp_ready) begin
            r_id_q.push_back(int'(resp_id));
            r_cyc_q.push_back(cyc);
            r_res_q.push_back(resp_result);
            r_zero_q.push_back(resp_zero);
          end
        end
        if (rst) begin
          m_ptr = 0; m_pend = 1'b0; m_last = 4'd0;
          m_a = 4'd0; m_b = 4'd0; m_op = 2'd0;
        end else if (g >= 0) begin
          m_pend = 1'b1; m_acc = cyc; m_id = g;
          m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W]; m_op = req_op[g*2 +: 2];
          m_res = alu_ref(m_a, m_b, m_op);
        end else if (m_pend && (cyc - m_acc) == 1) begin
          m_last = m_res;
        end else if (exp_rv && resp_ready) begin
          m_ptr = (m_id + 1) % N;
          m_pend = 1'b0;
        end
      end
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic wait_grants(input int want, input string name);
    int t;
    t = 0;
    while (g_id_q.size() < want && t < 60) begin
      tick(1);
      t++;
    end
    chk({name, "_grant_timeout"}, 32'(g_id_q.size() >= want), 32'd1);
  endtask

  task automatic wait_resps(input int want, input string name);
    int t;
    t = 0;
    while (r_id_q.size() < want && t < 60) begin
      tick(1);
      t++;
    end
    chk({name, "_resp_timeout"}, 32'(r_id_q.size() >= want), 32'd1);
  endtask

  task automatic do_reset(input logic [N-1:0] valid_during);
    rst = 1'b1;
    req_valid = valid_during;
    tick(2);
    rst = 1'b0;
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       zero;
  } vec_t;

  initial begin
    vec_t vt[5];
    int base, rbase, rel;

    vt[0] = '{0, 4'b1011, 4'b0010, 2'b00, 4'b0010, 1'b0};
    vt[1] = '{0, 4'b1000, 4'b0100, 2'b01, 4'b1100, 1'b0};
    vt[2] = '{0, 4'b1110, 4'b1110, 2'b10, 4'b1100, 1'b0};
    vt[3] = '{0, 4'b1111, 4'b0111, 2'b11, 4'b1000, 1'b0};
    vt[4] = '{2, 4'b0101, 4'b1010, 2'b00, 4'b0000, 1'b1};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b1;
    tick(2);
    chk_en = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_zero", 32'(resp_zero), 32'd1);
    chk("rst_alu_control", 32'(alu_control), 32'd0);

    // Directed vectors: one requester, one op each.
    for (int i = 0; i < 5; i++) begin
      base = g_id_q.size();
      rbase = r_id_q.size();
      set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
      req_valid = '0;
      req_valid[vt[i].id] = 1'b1;
      wait_grants(base + 1, "vec");
      req_valid = '0;
      wait_resps(rbase + 1, "vec");
      if (g_id_q.size() > base && r_id_q.size() > rbase) begin
        chk("vec_grant_id", 32'(g_id_q[base]), 32'(vt[i].id));
        chk("vec_resp_id", 32'(r_id_q[rbase]), 32'(vt[i].id));
        chk("vec_result", 32'(r_res_q[rbase]), 32'(vt[i].res));
        chk("vec_zero", 32'(r_zero_q[rbase]), 32'(vt[i].zero));
        chk("vec_latency", 32'(r_cyc_q[rbase] - g_cyc_q[base]), 32'd2);
      end
      tick(2);
    end

    // Round-robin with all requesters valid from reset.
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 3), 4'(2 * i + 1), 2'(i));
    resp_ready = 1'b1;
    do_reset(4'hF);
    base = g_id_q.size();
    rbase = r_id_q.size();
    wait_grants(base + 6, "rr");
    req_valid = '0;
    tick(6);
    if (g_id_q.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("rr_order", 32'(g_id_q[base + k]), 32'(k % N));
        if (k > 0) chk("rr_spacing", 32'(g_cyc_q[base + k] - g_cyc_q[base + k - 1]), 32'd3);
      end
    end
    if (r_id_q.size() >= rbase + 6) begin
      for (int k = 0; k < 6; k++) chk("rr_resp_id", 32'(r_id_q[rbase + k]), 32'(k % N));
    end

    // Backpressure: hold the response for 5 cycles.
    do_reset('0);
    resp_ready = 1'b0;
    req_valid = 4'b0110;
    base = g_id_q.size();
    wait_grants(base + 1, "bp");
    tick(1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_no_grant", 32'(g_id_q.size()), 32'(base + 1));
      tick(1);
    end
    rel = cyc;
    resp_ready = 1'b1;
    wait_grants(base + 2, "bp");
    req_valid = '0;
    if (g_id_q.size() >= base + 2) begin
      chk("bp_next_delay", 32'(g_cyc_q[base + 1] - rel), 32'd1);
      chk("bp_next_id", 32'(g_id_q[base + 1]), 32'd2);
    end
    tick(5);

    // Reset during EXEC for requester 3 (rr pointer is 3 here).
    set_req(3, 4'b1010, 4'b0011, 2'b11);
    req_valid = 4'b1000;
    base = g_id_q.size();
    rbase = r_id_q.size();
    wait_grants(base + 1, "rst_mid");
    rst = 1'b1;
    req_valid = '0;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_alu_control", 32'(alu_control), 32'd0);
    tick(4);
    chk("rst_mid_no_resp", 32'(r_id_q.size()), 32'(rbase));
    req_valid = 4'b1010;
    wait_grants(base + 2, "rst_mid");
    req_valid = '0;
    if (g_id_q.size() >= base + 2) chk("rst_mid_next_id", 32'(g_id_q[base + 1]), 32'd1);
    tick(5);

    // Requester 1 pulses valid only while requester 0 is in RESP.
    do_reset('0);
    resp_ready = 1'b0;
    set_req(0, 4'b0011, 4'b0101, 2'b10);
    set_req(1, 4'b0110, 4'b0001, 2'b01);
    req_valid = 4'b0001;
    base = g_id_q.size();
    rbase = r_id_q.size();
    wait_grants(base + 1, "wd");
    req_valid = '0;
    tick(1);
    req_valid = 4'b0010;
    tick(2);
    req_valid = '0;
    resp_ready = 1'b1;
    tick(7);
    chk("wd_grants", 32'(g_id_q.size()), 32'(base + 1));
    chk("wd_resps", 32'(r_id_q.size()), 32'(rbase + 1));
    if (r_id_q.size() > rbase) chk("wd_resp_id", 32'(r_id_q[rbase]), 32'd0);

    // Randomized traffic against the reference model.
    do_reset('0);
    base = g_id_q.size();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(i, 4'($urandom), 4'($urandom), 2'($urandom));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      tick(1);
    end
    rst = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    tick(5);
    chk("rand_activity", 32'(g_id_q.size() > base + 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
